htu_nway_pipe: RTL and testbench

Parametrised next-generation hit-test pipeline for the HTU. It arbitrates several upstream bank-request channels and performs an N-way tag lookup against flop-based tag/valid/dirty state. It picks victims with a per-set tree-PLRU and issues refill (AR) and writeback (AW) requests to the memory controller. A pending-refill set table blocks requests to sets whose refill is still outstanding.

---
 rtl/htu_nway_pipe.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_htu_nway_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/htu_nway_pipe.sv
// htu_nway_pipe: N-way hit-test pipeline with round-robin intake, tree-PLRU victims,
// pending-refill set blocking and AR/AW issue. Define HTU_PERF_CNT_EN for hit/miss counters.
module htu_nway_pipe #(
    parameter int WAYS   = 4,
    parameter int SETS   = 64,
    parameter int ADDR_W = 32,
    parameter int LINE_B = 64,
    parameter int ID_W   = 4,
    parameter int REQ_CH = 2,
    parameter int PEND   = 4,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS),
    localparam int OFF_W = $clog2(LINE_B),
    localparam int TAG_W = ADDR_W - SET_W - OFF_W,
    localparam int CH_W  = (REQ_CH > 1) ? $clog2(REQ_CH) : 1,
    localparam int PND_W = (PEND > 1) ? $clog2(PEND) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQ_CH-1:0]        u_req_valid,
    output logic [REQ_CH-1:0]        u_req_ready,
    input  logic [REQ_CH*ADDR_W-1:0] u_req_addr,
    input  logic [REQ_CH*2-1:0]      u_req_op,
    input  logic [REQ_CH*ID_W-1:0]   u_req_id,
    output logic                     d_isu_valid,
    input  logic                     d_isu_ready,
    output logic                     d_isu_hit,
    output logic [WAY_W-1:0]         d_isu_way,
    output logic [SET_W-1:0]         d_isu_set,
    output logic [1:0]               d_isu_op,
    output logic [ID_W-1:0]          d_isu_id,
    output logic [CH_W-1:0]          d_isu_ch,
    output logic                     d_memctl_awvalid,
    input  logic                     d_memctl_awready,
    output logic [ADDR_W-1:0]        d_memctl_awaddr,
    output logic [ID_W-1:0]          d_memctl_awid,
    output logic                     d_memctl_arvalid,
    input  logic                     d_memctl_arready,
    output logic [ADDR_W-1:0]        d_memctl_araddr,
    output logic [ID_W-1:0]          d_memctl_arid,
    input  logic                     d_refill_done_valid,
    input  logic [SET_W-1:0]         d_refill_done_set
`ifdef HTU_PERF_CNT_EN
    ,
    output logic [31:0]              perf_hit_cnt,
    output logic [31:0]              perf_miss_cnt
`endif
);

    // Tree walk: bit 0 steers to the left child (2n+1), bit 1 to the right (2n+2).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            way  = WAY_W'({way, bits[node]});
            node = WAY_W'((32'(node) << 32'd1) + 32'd1 + 32'(bits[node]));
        end
        return way;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0]  nb;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] w;
        logic             b;
        nb   = bits;
        node = '0;
        w    = way;
        for (int l = 0; l < WAY_W; l++) begin
            b        = w[WAY_W-1];
            nb[node] = ~b;
            node     = WAY_W'((32'(node) << 32'd1) + 32'd1 + 32'(b));
            w        = w << 32'd1;
        end
        return nb;
    endfunction

    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-2:0]            plru_q, plru_d;
    logic [PEND-1:0]                      pend_v_q, pend_v_d;
    logic [PEND-1:0][SET_W-1:0]           pend_set_q, pend_set_d;
    logic [CH_W-1:0]                      rr_q, rr_d;
    logic                                 isu_v_q, isu_v_d, aw_v_q, aw_v_d, ar_v_q, ar_v_d;
    logic                                 hit_q, hit_d;
    logic [WAY_W-1:0]                     way_q, way_d;
    logic [SET_W-1:0]                     set_q, set_d;
    logic [1:0]                           op_q, op_d;
    logic [ID_W-1:0]                      id_q, id_d, awid_q, awid_d, arid_q, arid_d;
    logic [CH_W-1:0]                      ch_q, ch_d;
    logic [ADDR_W-1:0]                    awaddr_q, awaddr_d, araddr_q, araddr_d;

    logic [ADDR_W-1:0] ch_addr_s [REQ_CH];
    logic [1:0]        ch_op_s   [REQ_CH];
    logic [ID_W-1:0]   ch_id_s   [REQ_CH];
    logic [REQ_CH-1:0] elig_s;
    logic              grant_vld_s, accept_s, out_free_s, pend_full_s;
    logic [CH_W-1:0]   grant_ch_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [SET_W-1:0]  sel_set_s;
    logic [TAG_W-1:0]  sel_tag_s;
    logic [1:0]        sel_op_s;
    logic [ID_W-1:0]   sel_id_s;
    logic [WAYS-1:0]   match_s;
    logic              hit_s, is_wr_s;
    logic [WAY_W-1:0]  hit_way_s, inv_way_s, victim_way_s;
    logic [PND_W-1:0]  free_idx_s;

    // Unpack channels and block any channel whose set has an outstanding refill.
    always_comb begin
        for (int c = 0; c < REQ_CH; c++) begin
            ch_addr_s[c] = u_req_addr[c*ADDR_W +: ADDR_W];
            ch_op_s[c]   = u_req_op[c*2 +: 2];
            ch_id_s[c]   = u_req_id[c*ID_W +: ID_W];
            elig_s[c]    = u_req_valid[c];
            for (int p = 0; p < PEND; p++) begin
                elig_s[c] = elig_s[c] &
                            ~(pend_v_q[p] & (pend_set_q[p] == ch_addr_s[c][OFF_W +: SET_W]));
            end
        end
    end

    // Round-robin pick starting at the pointer.
    always_comb begin
        int idx;
        grant_vld_s = 1'b0;
        grant_ch_s  = '0;
        for (int k = 0; k < REQ_CH; k++) begin
            idx = (int'(rr_q) + k) % REQ_CH;
            if (!grant_vld_s && elig_s[idx]) begin
                grant_vld_s = 1'b1;
                grant_ch_s  = CH_W'(idx);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Tag lookup and victim/free-slot selection for the granted request.
    always_comb begin
        sel_addr_s = ch_addr_s[grant_ch_s];
        sel_op_s   = ch_op_s[grant_ch_s];
        sel_id_s   = ch_id_s[grant_ch_s];
        sel_set_s  = sel_addr_s[OFF_W +: SET_W];
        sel_tag_s  = sel_addr_s[ADDR_W-1 -: TAG_W];
        is_wr_s    = (sel_op_s == 2'd1);
        hit_way_s  = '0;
        inv_way_s  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match_s[w] = valid_q[sel_set_s][w] & (tag_q[sel_set_s][w] == sel_tag_s);
            hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
            inv_way_s  = valid_q[sel_set_s][w] ? inv_way_s : WAY_W'(w);
        end
        hit_s        = |match_s;
        victim_way_s = (&valid_q[sel_set_s]) ? plru_victim(plru_q[sel_set_s]) : inv_way_s;
        free_idx_s   = '0;
        for (int p = PEND - 1; p >= 0; p--) begin
            free_idx_s = pend_v_q[p] ? free_idx_s : PND_W'(p);
        end
        pend_full_s = &pend_v_q;
        out_free_s  = (~isu_v_q | d_isu_ready) & (~aw_v_q | d_memctl_awready) &
                      (~ar_v_q | d_memctl_arready);
        accept_s    = rst_n & grant_vld_s & out_free_s & ~pend_full_s;
        for (int c = 0; c < REQ_CH; c++) begin
            u_req_ready[c] = accept_s & (grant_ch_s == CH_W'(c));
        end
    end

    // Next-state: drain the output stage, retire refills, apply the accepted lookup.
    always_comb begin
        tag_d      = tag_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        plru_d     = plru_q;
        pend_set_d = pend_set_q;
        rr_d       = rr_q;
        isu_v_d    = isu_v_q & ~d_isu_ready;
        aw_v_d     = aw_v_q & ~d_memctl_awready;
        ar_v_d     = ar_v_q & ~d_memctl_arready;
        hit_d      = hit_q;
        way_d      = way_q;
        set_d      = set_q;
        op_d       = op_q;
        id_d       = id_q;
        ch_d       = ch_q;
        awaddr_d   = awaddr_q;
        awid_d     = awid_q;
        araddr_d   = araddr_q;
        arid_d     = arid_q;
        for (int p = 0; p < PEND; p++) begin
            pend_v_d[p] = pend_v_q[p] &
                          ~(d_refill_done_valid & (pend_set_q[p] == d_refill_done_set));
        end
        if (accept_s) begin
            isu_v_d = 1'b1;
            aw_v_d  = 1'b0;
            ar_v_d  = 1'b0;
            hit_d   = hit_s;
            set_d   = sel_set_s;
            op_d    = sel_op_s;
            id_d    = sel_id_s;
            ch_d    = grant_ch_s;
            rr_d    = CH_W'((32'(grant_ch_s) + 32'd1) % REQ_CH);
            case (sel_op_s)
                2'd2: begin
                    way_d = hit_s ? hit_way_s : '0;
                    if (hit_s) begin
                        valid_d[sel_set_s][hit_way_s] = 1'b0;
                        dirty_d[sel_set_s][hit_way_s] = 1'b0;
                        aw_v_d   = dirty_q[sel_set_s][hit_way_s];
                        awaddr_d = {sel_tag_s, sel_set_s, {OFF_W{1'b0}}};
                        awid_d   = sel_id_s;
                    end else begin
                        aw_v_d = 1'b0;
                    end
                end
                default: begin
                    if (hit_s) begin
                        way_d                         = hit_way_s;
                        plru_d[sel_set_s]             = plru_touch(plru_q[sel_set_s], hit_way_s);
                        dirty_d[sel_set_s][hit_way_s] = dirty_q[sel_set_s][hit_way_s] | is_wr_s;
                    end else begin
                        way_d                            = victim_way_s;
                        tag_d[sel_set_s][victim_way_s]   = sel_tag_s;
                        valid_d[sel_set_s][victim_way_s] = 1'b1;
                        dirty_d[sel_set_s][victim_way_s] = is_wr_s;
                        plru_d[sel_set_s]        = plru_touch(plru_q[sel_set_s], victim_way_s);
                        pend_v_d[free_idx_s]     = 1'b1;
                        pend_set_d[free_idx_s]   = sel_set_s;
                        ar_v_d   = 1'b1;
                        araddr_d = {sel_tag_s, sel_set_s, {OFF_W{1'b0}}};
                        arid_d   = sel_id_s;
                        aw_v_d   = valid_q[sel_set_s][victim_way_s] &
                                   dirty_q[sel_set_s][victim_way_s];
                        awaddr_d = {tag_q[sel_set_s][victim_way_s], sel_set_s, {OFF_W{1'b0}}};
                        awid_d   = sel_id_s;
                    end
                end
            endcase
        end else begin
            rr_d = rr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '0; valid_q <= '0; dirty_q <= '0; plru_q <= '0;
            pend_v_q <= '0; pend_set_q <= '0; rr_q <= '0;
            isu_v_q <= 1'b0; aw_v_q <= 1'b0; ar_v_q <= 1'b0;
            hit_q <= 1'b0; way_q <= '0; set_q <= '0; op_q <= 2'd0; id_q <= '0; ch_q <= '0;
            awaddr_q <= '0; awid_q <= '0; araddr_q <= '0; arid_q <= '0;
        end else begin
            tag_q <= tag_d; valid_q <= valid_d; dirty_q <= dirty_d; plru_q <= plru_d;
            pend_v_q <= pend_v_d; pend_set_q <= pend_set_d; rr_q <= rr_d;
            isu_v_q <= isu_v_d; aw_v_q <= aw_v_d; ar_v_q <= ar_v_d;
            hit_q <= hit_d; way_q <= way_d; set_q <= set_d; op_q <= op_d; id_q <= id_d;
            ch_q <= ch_d; awaddr_q <= awaddr_d; awid_q <= awid_d;
            araddr_q <= araddr_d; arid_q <= arid_d;
        end
    end

    assign d_isu_valid      = isu_v_q;
    assign d_isu_hit        = hit_q;
    assign d_isu_way        = way_q;
    assign d_isu_set        = set_q;
    assign d_isu_op         = op_q;
    assign d_isu_id         = id_q;
    assign d_isu_ch         = ch_q;
    assign d_memctl_awvalid = aw_v_q;
    assign d_memctl_awaddr  = awaddr_q;
    assign d_memctl_awid    = awid_q;
    assign d_memctl_arvalid = ar_v_q;
    assign d_memctl_araddr  = araddr_q;
    assign d_memctl_arid    = arid_q;

`ifdef HTU_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters over accepted lookups.
    always_comb begin
        if (accept_s && hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (accept_s && !hit_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_htu_nway_pipe.sv
// Directed self-checking bench for htu_nway_pipe (default parameters: 4 ways, 64 sets,
// 64-byte lines, 2 channels, 4 pending entries).
module tb_htu_nway_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  u_req_valid, u_req_ready;
    logic [63:0] u_req_addr;
    logic [3:0]  u_req_op;
    logic [7:0]  u_req_id;
    logic        d_isu_valid, d_isu_ready, d_isu_hit;
    logic [1:0]  d_isu_way, d_isu_op;
    logic [5:0]  d_isu_set;
    logic [3:0]  d_isu_id;
    logic        d_isu_ch;
    logic        d_memctl_awvalid, d_memctl_awready, d_memctl_arvalid, d_memctl_arready;
    logic [31:0] d_memctl_awaddr, d_memctl_araddr;
    logic [3:0]  d_memctl_awid, d_memctl_arid;
    logic        d_refill_done_valid;
    logic [5:0]  d_refill_done_set;
`ifdef HTU_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, FL = 2'd2;

    htu_nway_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .u_req_valid(u_req_valid), .u_req_ready(u_req_ready), .u_req_addr(u_req_addr),
        .u_req_op(u_req_op), .u_req_id(u_req_id),
        .d_isu_valid(d_isu_valid), .d_isu_ready(d_isu_ready), .d_isu_hit(d_isu_hit),
        .d_isu_way(d_isu_way), .d_isu_set(d_isu_set), .d_isu_op(d_isu_op),
        .d_isu_id(d_isu_id), .d_isu_ch(d_isu_ch),
        .d_memctl_awvalid(d_memctl_awvalid), .d_memctl_awready(d_memctl_awready),
        .d_memctl_awaddr(d_memctl_awaddr), .d_memctl_awid(d_memctl_awid),
        .d_memctl_arvalid(d_memctl_arvalid), .d_memctl_arready(d_memctl_arready),
        .d_memctl_araddr(d_memctl_araddr), .d_memctl_arid(d_memctl_arid),
        .d_refill_done_valid(d_refill_done_valid), .d_refill_done_set(d_refill_done_set)
`ifdef HTU_PERF_CNT_EN
        , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [1:0] op,
                           input logic [3:0] id);
        u_req_addr[ch*32 +: 32] = addr;
        u_req_op[ch*2 +: 2]     = op;
        u_req_id[ch*4 +: 4]     = id;
        u_req_valid[ch]         = 1'b1;
    endtask

    // Drive a request until accepted (bounded); returns at accept edge + 1.
    task automatic issue(input int ch, input logic [31:0] addr, input logic [1:0] op,
                         input logic [3:0] id);
        bit got;
        got = 1'b0;
        set_req(ch, addr, op, id);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = u_req_ready[ch];
            @(posedge clk); #1;
        end
        u_req_valid[ch] = 1'b0;
        chk("accept", 64'(got), 64'd1);
    endtask

    task automatic done_pulse(input logic [5:0] set);
        d_refill_done_set   = set;
        d_refill_done_valid = 1'b1;
        @(posedge clk); #1;
        d_refill_done_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; u_req_valid = 2'b00; u_req_addr = 64'd0; u_req_op = 4'd0;
        u_req_id = 8'd0; d_isu_ready = 1'b1; d_memctl_awready = 1'b1;
        d_memctl_arready = 1'b1; d_refill_done_valid = 1'b0; d_refill_done_set = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_isu_v", 64'(d_isu_valid), 64'd0);
        chk("rst_ar_v", 64'(d_memctl_arvalid), 64'd0);
        chk("rst_aw_v", 64'(d_memctl_awvalid), 64'd0);
        chk("rst_araddr", 64'(d_memctl_araddr), 64'd0);
        chk("rst_awaddr", 64'(d_memctl_awaddr), 64'd0);
        rst_n = 1'b1;

        // Round-robin: two channels of flush misses (no state, no pending entries).
        set_req(0, 32'h0000_7000, FL, 4'd2);
        set_req(1, 32'h0000_7040, FL, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready", 64'(u_req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk); #1;
            chk("rr_isu_ch", 64'(d_isu_ch), 64'(i % 2));
            chk("rr_isu_hit", 64'(d_isu_hit), 64'd0);
        end
        u_req_valid = 2'b00;

        // Cold read miss, then a blocked repeat until the refill completes.
        issue(0, 32'h0000_1000, RD, 4'd1);
        chk("cold_isu_v", 64'(d_isu_valid), 64'd1);
        chk("cold_hit", 64'(d_isu_hit), 64'd0);
        chk("cold_way", 64'(d_isu_way), 64'd0);
        chk("cold_ar_v", 64'(d_memctl_arvalid), 64'd1);
        chk("cold_araddr", 64'(d_memctl_araddr), 64'h1000);
        chk("cold_arid", 64'(d_memctl_arid), 64'd1);
        chk("cold_aw_v", 64'(d_memctl_awvalid), 64'd0);
        set_req(0, 32'h0000_1000, RD, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pend_stall", 64'(u_req_ready), 64'd0);
            @(posedge clk); #1;
        end
        done_pulse(6'd0);
        issue(0, 32'h0000_1000, RD, 4'd2);
        chk("rehit_hit", 64'(d_isu_hit), 64'd1);
        chk("rehit_way", 64'(d_isu_way), 64'd0);
        chk("rehit_ar_v", 64'(d_memctl_arvalid), 64'd0);

        // Write hit dirties the line; flush writes it back; the next read misses.
        issue(0, 32'h0000_1000, WR, 4'd3);
        chk("wrhit_hit", 64'(d_isu_hit), 64'd1);
        chk("wrhit_aw_v", 64'(d_memctl_awvalid), 64'd0);
        issue(0, 32'h0000_1000, FL, 4'd4);
        chk("fl_hit", 64'(d_isu_hit), 64'd1);
        chk("fl_aw_v", 64'(d_memctl_awvalid), 64'd1);
        chk("fl_awaddr", 64'(d_memctl_awaddr), 64'h1000);
        chk("fl_awid", 64'(d_memctl_awid), 64'd4);
        chk("fl_ar_v", 64'(d_memctl_arvalid), 64'd0);
        issue(0, 32'h0000_1000, RD, 4'd5);
        chk("postfl_hit", 64'(d_isu_hit), 64'd0);
        chk("postfl_ar_v", 64'(d_memctl_arvalid), 64'd1);
        chk("postfl_aw_v", 64'(d_memctl_awvalid), 64'd0);
        done_pulse(6'd0);

        // Five write misses into set 3: ways fill 0..3, fifth evicts PLRU way 0 (tag 1).
        for (int k = 1; k <= 5; k++) begin
            issue(1, (32'(k) << 12) | 32'h0C0, WR, 4'(k));
            chk("s3_hit", 64'(d_isu_hit), 64'd0);
            chk("s3_way", 64'(d_isu_way), (k == 5) ? 64'd0 : 64'(k - 1));
            chk("s3_aw_v", 64'(d_memctl_awvalid), (k == 5) ? 64'd1 : 64'd0);
            chk("s3_araddr", 64'(d_memctl_araddr), 64'((32'(k) << 12) | 32'h0C0));
            if (k == 5) begin
                chk("s3_awaddr", 64'(d_memctl_awaddr), 64'h10C0);
                chk("s3_awid", 64'(d_memctl_awid), 64'd5);
            end
            done_pulse(6'd3);
        end

        // AR back-pressure: ISU completes, AR held, intake stalls until AR completes.
        d_memctl_arready = 1'b0;
        issue(0, 32'h0000_1080, RD, 4'd6);
        chk("arbp_isu_v", 64'(d_isu_valid), 64'd1);
        chk("arbp_ar_v", 64'(d_memctl_arvalid), 64'd1);
        set_req(1, 32'h0000_7040, FL, 4'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arbp_stall", 64'(u_req_ready), 64'd0);
            @(posedge clk); #1;
            chk("arbp_isu_done", 64'(d_isu_valid), 64'd0);
            chk("arbp_ar_held", 64'(d_memctl_arvalid), 64'd1);
        end
        d_memctl_arready = 1'b1;
        @(negedge clk);
        chk("arbp_release", 64'(u_req_ready), 64'd2);
        @(posedge clk); #1;
        u_req_valid[1] = 1'b0;
        chk("arbp_next_ch", 64'(d_isu_ch), 64'd1);
        chk("arbp_next_id", 64'(d_isu_id), 64'd7);
        chk("arbp_ar_clr", 64'(d_memctl_arvalid), 64'd0);
        done_pulse(6'd2);

        // Fill the pending table, then a done and a new miss in the same cycle.
        for (int s = 4; s < 8; s++) begin
            issue(0, 32'h0000_1000 | (32'(s) << 6), RD, 4'(s + 4));
        end
        set_req(0, 32'h0000_1200, RD, 4'd10);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_stall", 64'(u_req_ready), 64'd0);
            @(posedge clk); #1;
        end
        d_refill_done_set = 6'd4; d_refill_done_valid = 1'b1;
        @(posedge clk); #1;
        d_refill_done_set = 6'd5;
        @(negedge clk);
        chk("full_free", 64'(u_req_ready), 64'd1);
        @(posedge clk); #1;
        d_refill_done_valid = 1'b0;
        u_req_valid[0] = 1'b0;
        chk("same_cyc_hit", 64'(d_isu_hit), 64'd0);
        chk("same_cyc_araddr", 64'(d_memctl_araddr), 64'h1200);
        issue(1, 32'h0000_1140, RD, 4'd11);
        chk("set5_hit", 64'(d_isu_hit), 64'd1);
        set_req(0, 32'h0000_1200, RD, 4'd12);
        @(negedge clk);
        chk("set8_blocked", 64'(u_req_ready), 64'd0);
        @(posedge clk); #1;
        u_req_valid[0] = 1'b0;

        // Reset mid-operation drops the held AR and every pending entry.
        d_memctl_arready = 1'b0;
        issue(0, 32'h0000_1240, RD, 4'd13);
        chk("mr_ar_v", 64'(d_memctl_arvalid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mr_ar_drop", 64'(d_memctl_arvalid), 64'd0);
        chk("mr_isu_drop", 64'(d_isu_valid), 64'd0);
        rst_n = 1'b1;
        d_memctl_arready = 1'b1;
        issue(0, 32'h0000_1180, RD, 4'd14);
        chk("mr_fresh_miss", 64'(d_isu_hit), 64'd0);
        chk("mr_fresh_way", 64'(d_isu_way), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
